// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings and counter sizing.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_e;

    // Bits needed for a counter that must reach max_count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin and conditioned outputs; slave is the debouncer, master is the consuming logic.
interface btn_debounce_if;

    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic long_press;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  long_press
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output long_press
    );

endinterface

// File: rtl/sync_ff.sv
// N-stage synchroniser for an asynchronous pin; reset loads RST_VAL into every stage.
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, counter-qualified debounce FSM, registered edge pulses.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to build the long-press detector; otherwise long_press is 0.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter bit          ACTIVE_LOW_IN     = 1'b1,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000
) (
    input logic           clk,
    input logic           rst_n,
    btn_debounce_if.slave bus
);

    localparam int unsigned           CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_sync;
    logic             pressed;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (ACTIVE_LOW_IN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.btn_in),
        .q_o   (pin_sync)
    );

    assign pressed = pin_sync ^ ACTIVE_LOW_IN;

    // Qualification stops at CNT_LAST by leaving the ARM state, so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the pulse defaults below are overridden later in the same block.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q <= ARM_HI;
                        cnt_q   <= '0;
                    end
                end
                ARM_HI: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!pressed) begin
                        state_q <= ARM_LO;
                        cnt_q   <= '0;
                    end
                end
                ARM_LO: begin
                    if (pressed) begin
                        state_q <= HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned      HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Held in IDLE/ARM_HI so it is zero on entry to HIGH; an ARM_LO bounce keeps counting.
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (state_q == HIGH || state_q == ARM_LO) begin
            hold_d = hold_q;
            long_d = (hold_q == HOLD_LAST);
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign bus.long_press = long_q;
`else
    // The hold-time parameter stays declared so both builds share one parameter set.
    if (LONG_PRESS_CYCLES == 0) begin : g_long_press_unused
    end

    assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected pulses are queued with their cycle when stimulus is driven.
module tb_btn_debounce;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;
    localparam int          LAT  = SYNC + DEB;

    typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_LONG = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  sb[$];

    btn_debounce_if bus ();

    btn_debounce #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .ACTIVE_LOW_IN     (1'b1),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input int at_cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = at_cyc;
        sb.push_back(e);
    endtask

    task automatic take_ev(input ev_kind_e kind, input string tag);
        ev_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_kind"}, e.kind, kind);
            check({tag, "_cycle"}, cyc, e.cyc);
        end
    endtask

    // Monitor: every observed pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.btn_rise)   take_ev(EV_RISE, "rise");
            if (bus.btn_fall)   take_ev(EV_FALL, "fall");
            if (bus.long_press) take_ev(EV_LONG, "long");
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a press at the current negedge; the rise lands LAT edges after the first sampling edge.
    task automatic press(input bit expect_long);
        bus.btn_in = 1'b0;
        expect_ev(EV_RISE, cyc + 1 + LAT);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        if (expect_long) expect_ev(EV_LONG, cyc + 1 + LAT + LONG);
`else
        if (expect_long) begin end
`endif
    endtask

    task automatic release_btn();
        bus.btn_in = 1'b1;
        expect_ev(EV_FALL, cyc + 1 + LAT);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"}, bus.btn_level, 1'b0);
        check({tag, "_rise"},  bus.btn_rise,  1'b0);
        check({tag, "_fall"},  bus.btn_fall,  1'b0);
        check({tag, "_long"},  bus.long_press, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_in = 1'b1;
        rst_n      = 1'b0;

        // Reset with button released, then press while still in reset.
        wait_cyc(20);
        check_outputs_zero("reset");
        bus.btn_in = 1'b0;
        wait_cyc(3);
        check_outputs_zero("reset_held_press");
        rst_n = 1'b1;
        expect_ev(EV_RISE, cyc + 1 + LAT);
        wait_cyc(10);
        check("post_reset_level", bus.btn_level, 1'b1);
        release_btn();
        wait_cyc(10);
        check("post_reset_release_level", bus.btn_level, 1'b0);

        // Clean press and release with exact latency boundaries.
        press(1'b0);
        wait_cyc(LAT);
        check("clean_pre_rise_level", bus.btn_level, 1'b0);
        wait_cyc(1);
        check("clean_rise_level", bus.btn_level, 1'b1);
        wait_cyc(3);
        release_btn();
        wait_cyc(LAT);
        check("clean_pre_fall_level", bus.btn_level, 1'b1);
        wait_cyc(1);
        check("clean_fall_level", bus.btn_level, 1'b0);
        wait_cyc(5);

        // Bouncy press: two short low runs must both be rejected.
        bus.btn_in = 1'b0;
        wait_cyc(3);
        bus.btn_in = 1'b1;
        wait_cyc(1);
        bus.btn_in = 1'b0;
        wait_cyc(3);
        bus.btn_in = 1'b1;
        wait_cyc(10);
        check("bounce_level", bus.btn_level, 1'b0);
        press(1'b0);
        wait_cyc(10);
        check("bounce_then_hold_level", bus.btn_level, 1'b1);
        release_btn();
        wait_cyc(10);

        // Release glitch mid-press; the hold continues long enough for a long press.
        press(1'b1);
        wait_cyc(10);
        bus.btn_in = 1'b1;
        wait_cyc(2);
        bus.btn_in = 1'b0;
        wait_cyc(14);
        check("glitch_level", bus.btn_level, 1'b1);
        release_btn();
        wait_cyc(10);

        // Asynchronous reset during ARM_HI with cnt=2.
        bus.btn_in = 1'b0;
        wait_cyc(SYNC + 3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_arm_hi");
        wait_cyc(3);
        rst_n = 1'b1;
        expect_ev(EV_RISE, cyc + 1 + LAT);
        wait_cyc(10);
        check("requalified_level", bus.btn_level, 1'b1);

        // Asynchronous reset while the level is high.
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_press");
        wait_cyc(2);
        rst_n = 1'b1;
        expect_ev(EV_RISE, cyc + 1 + LAT);
        wait_cyc(10);
        check("requalified_again_level", bus.btn_level, 1'b1);
        release_btn();
        wait_cyc(10);

        // Long hold.
        press(1'b1);
        wait_cyc(40);
        check("long_hold_level", bus.btn_level, 1'b1);
        release_btn();
        wait_cyc(12);
        check("final_level", bus.btn_level, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
